ace_master_port: RTL and testbench

- Sits directly downstream of the L1 cache controller.
- Turns its single-bit read_req / write_req / invalid_req commands into ACE master transactions on the AR/R/AW/W/B channels, with the RACK/WACK acknowledges.
- Returns a one-cycle ace_ready pulse on completion.
- A full cache line moves as one INCR burst. Read data is assembled into rd_line for the cache datapath.

---
 rtl/ace_master_port.sv | 190 +++++++++++++++++++
 tb/tb_ace_master_port.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ace_master_port.sv
// ACE master port: converts single-bit cache controller commands into
// line-sized ACE transactions and returns a one-cycle completion pulse.
module ace_master_port #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             read_req,
    input  logic                             write_req,
    input  logic                             invalid_req,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [DATA_WIDTH*LINE_WORDS-1:0] wb_data,
    output logic                             ace_ready,
    output logic [DATA_WIDTH*LINE_WORDS-1:0] rd_line,
    output logic                             resp_err,
    output logic [ADDR_WIDTH-1:0]            araddr,
    output logic [7:0]                       arlen,
    output logic [3:0]                       arsnoop,
    output logic                             arvalid,
    input  logic                             arready,
    input  logic [DATA_WIDTH-1:0]            rdata,
    input  logic [3:0]                       rresp,
    input  logic                             rlast,
    input  logic                             rvalid,
    output logic                             rready,
    output logic                             rack,
    output logic [ADDR_WIDTH-1:0]            awaddr,
    output logic [7:0]                       awlen,
    output logic [2:0]                       awsnoop,
    output logic                             awvalid,
    input  logic                             awready,
    output logic [DATA_WIDTH-1:0]            wdata,
    output logic                             wlast,
    output logic                             wvalid,
    input  logic                             wready,
    input  logic [1:0]                       bresp,
    input  logic                             bvalid,
    output logic                             bready,
    output logic                             wack
);

    localparam int unsigned BEAT_W = $clog2(LINE_WORDS);
    localparam int unsigned OFF_W  = $clog2(LINE_WORDS * DATA_WIDTH / 8);
    localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(LINE_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFF_W;
    localparam logic [7:0]            BURST_LEN  = 8'(LINE_WORDS - 1);
    localparam logic [3:0]            SNOOP_READ_SHARED  = 4'b0001;
    localparam logic [3:0]            SNOOP_CLEAN_UNIQUE = 4'b1011;
    localparam logic [2:0]            SNOOP_WRITE_BACK   = 3'b011;

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE} state_t;
    typedef enum logic [1:0] {K_READ, K_INVAL, K_WRITE} kind_t;

    state_t                                 state_q, state_d;
    kind_t                                  kind_q, kind_d;
    logic [ADDR_WIDTH-1:0]                  addr_q, addr_d;
    logic [BEAT_W-1:0]                      beat_q, beat_d;
    logic [LINE_WORDS-1:0][DATA_WIDTH-1:0]  snap_q, snap_d;
    logic [LINE_WORDS-1:0][DATA_WIDTH-1:0]  line_q, line_d;
    logic                                   err_q, err_d;
    logic [BEAT_W-1:0]                      final_beat;

    // Upper response bits carry coherency state that this port does not track
    logic rresp_unused;
    assign rresp_unused = ^rresp[3:2];

    assign final_beat = (kind_q == K_READ) ? LAST_BEAT : '0;
    assign rd_line    = line_q;
    assign resp_err   = err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            kind_q  <= K_READ;
            addr_q  <= '0;
            beat_q  <= '0;
            snap_q  <= '0;
            line_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            snap_q  <= snap_d;
            line_q  <= line_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        snap_d  = snap_q;
        line_d  = line_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (write_req || invalid_req || read_req) begin
                    addr_d = req_addr & ALIGN_MASK;
                    beat_d = '0;
                    err_d  = 1'b0;
                    if (write_req) begin
                        kind_d  = K_WRITE;
                        snap_d  = wb_data;
                        state_d = S_AW;
                    end else begin
                        kind_d  = invalid_req ? K_INVAL : K_READ;
                        state_d = S_AR;
                    end
                end
            end
            S_AR: if (arready) state_d = S_R;
            S_R: begin
                if (rvalid) begin
                    if (kind_q == K_READ) line_d[beat_q] = rdata;
                    if (rresp[1:0] != 2'b00) err_d = 1'b1;
                    // A non-final beat at the expected final index means rlast is late
                    if (rlast) begin
                        if (beat_q != final_beat) err_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        if (beat_q == final_beat) err_d = 1'b1;
                        if (beat_q != LAST_BEAT) beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            S_AW: if (awready) state_d = S_W;
            S_W: begin
                if (wready) begin
                    if (beat_q == LAST_BEAT) state_d = S_B;
                    else                     beat_d  = beat_q + BEAT_W'(1);
                end
            end
            S_B: begin
                if (bvalid) begin
                    if (bresp != 2'b00) err_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Channel outputs registered from the next-state view so they align with the state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arvalid   <= 1'b0;
            araddr    <= '0;
            arlen     <= '0;
            arsnoop   <= '0;
            rready    <= 1'b0;
            awvalid   <= 1'b0;
            awaddr    <= '0;
            awlen     <= '0;
            awsnoop   <= '0;
            wvalid    <= 1'b0;
            wdata     <= '0;
            wlast     <= 1'b0;
            bready    <= 1'b0;
            ace_ready <= 1'b0;
            rack      <= 1'b0;
            wack      <= 1'b0;
        end else begin
            arvalid   <= (state_d == S_AR);
            araddr    <= (state_d == S_AR) ? addr_d : '0;
            arlen     <= (state_d == S_AR && kind_d == K_READ) ? BURST_LEN : '0;
            arsnoop   <= (state_d != S_AR) ? 4'b0000 :
                         (kind_d == K_INVAL) ? SNOOP_CLEAN_UNIQUE : SNOOP_READ_SHARED;
            rready    <= (state_d == S_R);
            awvalid   <= (state_d == S_AW);
            awaddr    <= (state_d == S_AW) ? addr_d : '0;
            awlen     <= (state_d == S_AW) ? BURST_LEN : '0;
            awsnoop   <= (state_d == S_AW) ? SNOOP_WRITE_BACK : '0;
            wvalid    <= (state_d == S_W);
            wdata     <= (state_d == S_W) ? snap_d[beat_d] : '0;
            wlast     <= (state_d == S_W) && (beat_d == LAST_BEAT);
            bready    <= (state_d == S_B);
            ace_ready <= (state_d == S_DONE);
            rack      <= (state_d == S_DONE) && (kind_d != K_WRITE);
            wack      <= (state_d == S_DONE) && (kind_d == K_WRITE);
        end
    end

endmodule

// File: tb/tb_ace_master_port.sv
// Self-checking bench for ace_master_port: directed scenarios plus randomized
// transactions against a line-level model of the expected ACE behaviour.
module tb_ace_master_port;

    localparam int unsigned AW     = 32;
    localparam int unsigned DW     = 32;
    localparam int unsigned LW     = 4;
    localparam int unsigned LINE_W = DW * LW;

    logic              clk = 1'b0;
    logic              reset;
    logic              read_req, write_req, invalid_req;
    logic [AW-1:0]     req_addr;
    logic [LINE_W-1:0] wb_data;
    logic              ace_ready;
    logic [LINE_W-1:0] rd_line;
    logic              resp_err;
    logic [AW-1:0]     araddr;
    logic [7:0]        arlen;
    logic [3:0]        arsnoop;
    logic              arvalid, arready;
    logic [DW-1:0]     rdata;
    logic [3:0]        rresp;
    logic              rlast, rvalid, rready, rack;
    logic [AW-1:0]     awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsnoop;
    logic              awvalid, awready;
    logic [DW-1:0]     wdata;
    logic              wlast, wvalid, wready;
    logic [1:0]        bresp;
    logic              bvalid, bready, wack;

    ace_master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW)) dut (
        .clk(clk), .reset(reset),
        .read_req(read_req), .write_req(write_req), .invalid_req(invalid_req),
        .req_addr(req_addr), .wb_data(wb_data),
        .ace_ready(ace_ready), .rd_line(rd_line), .resp_err(resp_err),
        .araddr(araddr), .arlen(arlen), .arsnoop(arsnoop), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready), .rack(rack),
        .awaddr(awaddr), .awlen(awlen), .awsnoop(awsnoop), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready), .wack(wack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected rd_line contents and per-beat stimulus for the next read
    logic [LINE_W-1:0] exp_line;
    logic [DW-1:0]     r_data [16];
    logic [3:0]        r_resp [16];
    bit                r_gap  [16];

    task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] line_addr(input logic [AW-1:0] a);
        return a & ~AW'(LW * DW / 8 - 1);
    endfunction

    task automatic fill_beats(input int n, input bit allow_err);
        for (int k = 0; k < n; k++) begin
            r_data[k] = $urandom;
            r_resp[k] = {2'($urandom_range(0, 3)), 2'b00};
            if (allow_err && $urandom_range(0, 7) == 0) r_resp[k][1:0] = 2'($urandom_range(1, 3));
            r_gap[k]  = ($urandom_range(0, 3) == 0);
        end
    endtask

    // Entered and left at a negedge with the port idle
    task automatic run_read(input bit inval, input logic [AW-1:0] addr, input int ardly, input int nbeats);
        bit exp_err;
        int final_beat;
        final_beat = inval ? 0 : LW - 1;
        exp_err    = (nbeats - 1 != final_beat);
        read_req    = !inval;
        invalid_req = inval;
        req_addr    = addr;
        @(negedge clk);
        read_req    = 1'b0;
        invalid_req = 1'b0;
        check("arvalid", LINE_W'(arvalid), LINE_W'(1));
        check("araddr", LINE_W'(araddr), LINE_W'(line_addr(addr)));
        check("arlen", LINE_W'(arlen), LINE_W'(inval ? 0 : LW - 1));
        check("arsnoop", LINE_W'(arsnoop), LINE_W'(inval ? 4'b1011 : 4'b0001));
        check("resp_err_clr", LINE_W'(resp_err), LINE_W'(0));
        repeat (ardly) begin
            @(negedge clk);
            check("arvalid_hold", LINE_W'(arvalid), LINE_W'(1));
            check("araddr_hold", LINE_W'(araddr), LINE_W'(line_addr(addr)));
        end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            if (r_gap[k]) begin
                rvalid = 1'b0;
                @(negedge clk);
            end
            check("rready", LINE_W'(rready), LINE_W'(1));
            rvalid = 1'b1;
            rdata  = r_data[k];
            rresp  = r_resp[k];
            rlast  = (k == nbeats - 1);
            if (r_resp[k][1:0] != 2'b00) exp_err = 1'b1;
            if (!inval) exp_line[((k < LW) ? k : LW - 1) * DW +: DW] = r_data[k];
            @(negedge clk);
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = '0;
        check("ace_ready_rd", LINE_W'(ace_ready), LINE_W'(1));
        check("rack", LINE_W'(rack), LINE_W'(1));
        check("wack_rd", LINE_W'(wack), LINE_W'(0));
        check("resp_err_rd", LINE_W'(resp_err), LINE_W'(exp_err));
        check("rd_line", rd_line, exp_line);
        @(negedge clk);
        check("ace_ready_pulse", LINE_W'(ace_ready), LINE_W'(0));
        check("rack_pulse", LINE_W'(rack), LINE_W'(0));
    endtask

    task automatic run_write(input logic [AW-1:0] addr, input logic [LINE_W-1:0] line, input int awdly,
                             input int bdly, input logic [1:0] br, input bit chain, input logic [AW-1:0] next_addr);
        int beat;
        int stall;
        write_req = 1'b1;
        req_addr  = addr;
        wb_data   = line;
        @(negedge clk);
        write_req = 1'b0;
        wb_data   = {$urandom, $urandom, $urandom, $urandom};
        check("awvalid", LINE_W'(awvalid), LINE_W'(1));
        check("awaddr", LINE_W'(awaddr), LINE_W'(line_addr(addr)));
        check("awlen", LINE_W'(awlen), LINE_W'(LW - 1));
        check("awsnoop", LINE_W'(awsnoop), LINE_W'(3'b011));
        check("resp_err_clr", LINE_W'(resp_err), LINE_W'(0));
        repeat (awdly) begin
            @(negedge clk);
            check("awvalid_hold", LINE_W'(awvalid), LINE_W'(1));
            check("wvalid_early", LINE_W'(wvalid), LINE_W'(0));
        end
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        beat  = 0;
        stall = 0;
        while (beat < LW) begin
            check("wvalid", LINE_W'(wvalid), LINE_W'(1));
            check("wdata", LINE_W'(wdata), LINE_W'(line[beat * DW +: DW]));
            check("wlast", LINE_W'(wlast), LINE_W'(beat == LW - 1));
            wready = ($urandom_range(0, 1) == 1) || (stall >= 2);
            stall  = wready ? 0 : stall + 1;
            @(negedge clk);
            if (wready) beat++;
        end
        wready = 1'b0;
        repeat (bdly) begin
            check("bready_wait", LINE_W'(bready), LINE_W'(1));
            @(negedge clk);
        end
        check("bready", LINE_W'(bready), LINE_W'(1));
        bvalid = 1'b1;
        bresp  = br;
        @(negedge clk);
        bvalid = 1'b0;
        bresp  = '0;
        check("ace_ready_wr", LINE_W'(ace_ready), LINE_W'(1));
        check("wack", LINE_W'(wack), LINE_W'(1));
        check("rack_wr", LINE_W'(rack), LINE_W'(0));
        check("resp_err_wr", LINE_W'(resp_err), LINE_W'(br != 2'b00));
        if (chain) begin
            read_req = 1'b1;
            req_addr = next_addr;
        end
        @(negedge clk);
        check("ace_ready_pulse", LINE_W'(ace_ready), LINE_W'(0));
        check("arvalid_idle", LINE_W'(arvalid), LINE_W'(0));
    endtask

    initial begin
        reset = 1'b0;
        read_req = 1'b0; write_req = 1'b0; invalid_req = 1'b0;
        req_addr = '0; wb_data = '0;
        arready = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bresp = '0; bvalid = 1'b0;
        exp_line = '0;
        repeat (2) @(negedge clk);
        check("rst_ace_ready", LINE_W'(ace_ready), LINE_W'(0));
        check("rst_rd_line", rd_line, '0);
        check("rst_resp_err", LINE_W'(resp_err), LINE_W'(0));
        check("rst_valids", LINE_W'({arvalid, awvalid, wvalid, rready, bready, rack, wack}), LINE_W'(0));
        reset = 1'b1;
        @(negedge clk);

        // Default read of the documented beat pattern
        for (int k = 0; k < 4; k++) begin
            r_data[k] = DW'(32'hA0 + k);
            r_resp[k] = '0;
            r_gap[k]  = 1'b0;
        end
        run_read(1'b0, 32'h0000_1234, 0, 4);
        check("rd_line_a", rd_line, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

        // Backpressured write, then a read asserted during its DONE cycle
        run_write(32'h2000_0048, {32'hD3D3_D3D3, 32'hD2D2_D2D2, 32'hD1D1_D1D1, 32'hD0D0_D0D0},
                  3, 1, 2'b00, 1'b1, 32'h0000_567C);
        fill_beats(4, 1'b0);
        run_read(1'b0, 32'h0000_567C, 0, 4);

        // CleanUnique leaves rd_line untouched
        fill_beats(1, 1'b0);
        run_read(1'b1, 32'h0000_9ABC, 1, 1);

        // Error reporting and clearing
        fill_beats(4, 1'b0);
        r_resp[1] = 4'h2;
        run_read(1'b0, 32'h0000_0100, 0, 4);
        fill_beats(2, 1'b0);
        run_read(1'b0, 32'h0000_0200, 0, 2);
        fill_beats(6, 1'b0);
        run_read(1'b0, 32'h0000_0300, 0, 6);
        run_write(32'h0000_0400, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 2'b11, 1'b0, '0);
        fill_beats(4, 1'b0);
        run_read(1'b0, 32'h0000_0500, 0, 4);

        // Reset in the middle of the write data burst
        write_req = 1'b1;
        req_addr  = 32'h0000_0600;
        wb_data   = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        write_req = 1'b0;
        awready   = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        wready  = 1'b1;
        repeat (2) @(negedge clk);
        check("wvalid_b2", LINE_W'(wvalid), LINE_W'(1));
        #2 reset = 1'b0;
        #1;
        check("rst_async_wvalid", LINE_W'(wvalid), LINE_W'(0));
        check("rst_async_awvalid", LINE_W'(awvalid), LINE_W'(0));
        check("rst_async_ace_ready", LINE_W'(ace_ready), LINE_W'(0));
        check("rst_async_rd_line", rd_line, '0);
        wready   = 1'b0;
        exp_line = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_idle", LINE_W'({arvalid, awvalid, wvalid, ace_ready}), LINE_W'(0));
        fill_beats(4, 1'b0);
        run_read(1'b0, 32'h0000_0700, 0, 4);

        // Randomized mix of transactions
        for (int t = 0; t < 30; t++) begin
            int kind;
            int nb;
            kind = $urandom_range(0, 2);
            if (kind == 2) begin
                run_write($urandom, {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3),
                          $urandom_range(0, 2), ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                          1'b0, '0);
            end else begin
                if (kind == 1) nb = ($urandom_range(0, 5) == 0) ? 2 : 1;
                else           nb = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 6) : LW;
                fill_beats(nb, 1'b1);
                run_read(kind == 1, $urandom, $urandom_range(0, 3), nb);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
